// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: next-PC select encodings, boot address
// and the fetch-unit state encoding.
package mips_pkg;

    localparam logic [2:0] NPC_SEQ = 3'b000;
    localparam logic [2:0] NPC_BEQ = 3'b001;
    localparam logic [2:0] NPC_JAL = 3'b010;
    localparam logic [2:0] NPC_J   = 3'b011;
    localparam logic [2:0] NPC_JR  = 3'b100;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/npc.sv
// Combinational next-PC generator: sequential, beq, jal/j and jr targets.
module npc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [2:0]  npc_sel,
    input  logic        zero,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_data,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    assign pc_plus4 = pc + 32'd4;

    // Unused encodings (101..111) fall through to sequential flow.
    always_comb begin
        next_pc = pc_plus4;
        case (npc_sel)
            NPC_BEQ: if (zero) next_pc = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
            NPC_JAL,
            NPC_J:   next_pc = {pc_plus4[31:28], imm26, 2'b00};
            NPC_JR:  next_pc = rs_data & 32'hFFFF_FFFC;
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: holds pc, issues one fetch at a time and keeps the
// fetched word until the core retires it, then moves pc to the next-PC value.
module ifu
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  npc_sel,
    input  logic        zero,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_data,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] next_pc;

    npc u_npc (
        .pc       (pc_q),
        .npc_sel  (npc_sel),
        .zero     (zero),
        .imm16    (imm16),
        .imm26    (imm26),
        .rs_data  (rs_data),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc)
    );

    // Each state only listens to its own event, so a stray ack in READY or an
    // early advance in FETCH has no effect.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = READY;
                end
            end
            READY: begin
                if (advance) begin
                    pc_d          = next_pc;
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        // Request is registered from the next state so it tracks FETCH exactly.
        imem_req_d = (state_d == FETCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= PC_RESET;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign imem_req    = imem_req_q;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed boot/branch/jump/stall/reset steps followed by a
// randomized run, all checked against a transaction-level pc/instr model.
module tb_ifu;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  npc_sel;
    logic        zero;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs_data;
    logic        advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int checks = 0;
    int errors = 0;

    // Model state: architectural pc and the word the core should be holding.
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    ifu dut (
        .clk         (clk),
        .rst         (rst),
        .npc_sel     (npc_sel),
        .zero        (zero),
        .imm16       (imm16),
        .imm26       (imm26),
        .rs_data     (rs_data),
        .advance     (advance),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_npc(input logic [31:0] cur, input logic [2:0] sel,
                                            input logic z, input logic [15:0] i16,
                                            input logic [25:0] i26, input logic [31:0] rs);
        logic [31:0] seq;
        int          off;
        seq = cur + 32'd4;
        off = int'($signed(i16));
        case (sel)
            3'd1:      return z ? 32'(seq + 32'(off * 4)) : seq;
            3'd2, 3'd3: return (seq & 32'hF000_0000) + 32'(32'(i26) * 4);
            3'd4:      return rs - (rs % 4);
            default:   return seq;
        endcase
    endfunction

    // Entered at a negedge with the DUT in FETCH; stalls, then acks.
    task automatic fetch(input int waits, input logic [31:0] word);
        for (int i = 0; i < waits; i++) begin
            chk("stall_req", {31'd0, imem_req}, 32'd1);
            chk("stall_addr", imem_addr, m_pc);
            chk("stall_valid", {31'd0, instr_valid}, 32'd0);
            advance = 1'($urandom);
            npc_sel = 3'($urandom);
            rs_data = $urandom;
            @(negedge clk);
        end
        advance    = 1'($urandom);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        advance  = 1'b0;
        m_instr  = word;
        chk("fetch_valid", {31'd0, instr_valid}, 32'd1);
        chk("fetch_instr", instr, m_instr);
        chk("fetch_pc", pc, m_pc);
        chk("ready_req", {31'd0, imem_req}, 32'd0);
    endtask

    // Entered at a negedge in READY; holds with spurious acks, then retires.
    task automatic retire(input logic [2:0] sel, input logic z, input logic [15:0] i16,
                          input logic [25:0] i26, input logic [31:0] rs,
                          input int holds, input logic with_ack);
        for (int i = 0; i < holds; i++) begin
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            advance    = 1'b0;
            @(negedge clk);
            chk("hold_instr", instr, m_instr);
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_pc", pc, m_pc);
        end
        npc_sel    = sel;
        zero       = z;
        imm16      = i16;
        imm26      = i26;
        rs_data    = rs;
        advance    = 1'b1;
        imem_ack   = with_ack;
        imem_rdata = $urandom;
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        @(negedge clk);
        advance  = 1'b0;
        imem_ack = 1'b0;
        m_pc     = ref_npc(m_pc, sel, z, i16, i26, rs);
        chk("retire_pc", pc, m_pc);
        chk("retire_addr", imem_addr, m_pc);
        chk("retire_valid", {31'd0, instr_valid}, 32'd0);
        chk("retire_req", {31'd0, imem_req}, 32'd1);
        chk("retire_instr", instr, m_instr);
    endtask

    initial begin
        rst = 1'b1; npc_sel = 3'd0; zero = 1'b0; imm16 = 16'd0; imm26 = 26'd0;
        rs_data = 32'd0; advance = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
        m_pc = 32'h0000_3000; m_instr = 32'd0;

        // Boot
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("boot_addr", imem_addr, 32'h0000_3000);
        fetch(3, 32'h3C01_1234);
        chk("boot_instr", instr, 32'h3C01_1234);

        // beq taken / not taken
        retire(NPC_SEQ, 1'b0, 16'd0, 26'd0, 32'd0, 2, 1'b0);
        fetch(1, $urandom);
        retire(NPC_BEQ, 1'b1, 16'hFFFF, 26'd0, 32'd0, 1, 1'b0);
        chk("beq_taken", pc, 32'h0000_3004);
        fetch(0, $urandom);
        retire(NPC_BEQ, 1'b0, 16'hFFFF, 26'd0, 32'd0, 0, 1'b0);
        chk("beq_not_taken", pc, 32'h0000_3008);

        // jal, then back to 3010 via jr, then j
        fetch(2, $urandom);
        retire(NPC_SEQ, 1'b0, 16'd0, 26'd0, 32'd0, 0, 1'b0);
        fetch(0, $urandom);
        retire(NPC_SEQ, 1'b0, 16'd0, 26'd0, 32'd0, 0, 1'b0);
        fetch(0, $urandom);
        retire(NPC_JAL, 1'b0, 16'd0, 26'h0000C10, 32'd0, 0, 1'b0);
        chk("jal_pc", pc, 32'h0000_3040);
        fetch(1, $urandom);
        retire(NPC_JR, 1'b0, 16'd0, 26'd0, 32'h0000_3010, 0, 1'b0);
        fetch(0, $urandom);
        retire(NPC_J, 1'b0, 16'd0, 26'h0000C10, 32'd0, 0, 1'b0);
        chk("j_pc", pc, 32'h0000_3040);

        // jr masks low bits; ack coincident with advance in READY
        fetch(0, $urandom);
        retire(NPC_JR, 1'b0, 16'd0, 26'd0, 32'h0000_3023, 3, 1'b1);
        chk("jr_pc", pc, 32'h0000_3020);

        // Sequential wraparound past the top of the address space
        fetch(0, $urandom);
        retire(NPC_JR, 1'b0, 16'd0, 26'd0, 32'hFFFF_FFFE, 0, 1'b0);
        fetch(0, $urandom);
        retire(NPC_SEQ, 1'b0, 16'd0, 26'd0, 32'd0, 0, 1'b0);
        chk("wrap_pc", pc, 32'h0000_0000);

        // Reset mid-fetch with an ack in the first IDLE cycle
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        m_pc     = 32'h0000_3000;
        m_instr  = 32'd0;
        chk("midrst_pc", pc, 32'h0000_3000);
        chk("midrst_drop_valid", {31'd0, instr_valid}, 32'd0);
        chk("midrst_drop_instr", instr, 32'd0);
        chk("midrst_refetch_addr", imem_addr, 32'h0000_3000);
        chk("midrst_refetch_req", {31'd0, imem_req}, 32'd1);
        fetch(1, 32'h2001_0005);

        // Randomized run
        for (int n = 0; n < 60; n++) begin
            retire(3'($urandom), 1'($urandom), 16'($urandom), 26'($urandom), $urandom,
                   int'($urandom_range(0, 2)), 1'($urandom));
            fetch(int'($urandom_range(0, 3)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
